// File: rtl/sram_bus_pkg.sv
// ------------------------------------------------------------------
// sram_bus_pkg : shared types and timing defaults for the SRAM master. Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package sram_bus_pkg;

   localparam int C_PH_W           = 4;
   localparam int C_SETUP_CYC_DEF  = 1;
   localparam int C_PULSE_CYC_DEF  = 2;
   localparam int C_ACCESS_CYC_DEF = 2;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SETUP   = 3'd1,
      ST_WPULSE  = 3'd2,
      ST_WHOLD   = 3'd3,
      ST_RACCESS = 3'd4
   } state_e;

endpackage

`default_nettype wire

// File: rtl/sram_phase_counter.sv
// ------------------------------------------------------------------
// sram_phase_counter : loadable down-counter, flags the last cycle of a phase. Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module sram_phase_counter
   import sram_bus_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_i,
   input  logic [C_PH_W-1:0] load_val_i,
   output logic              tc_o
);

   logic [C_PH_W-1:0] cnt_q, cnt_d;

   // A zero load would never reach terminal count, so it behaves as one cycle.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = (load_val_i == '0) ? C_PH_W'(1) : load_val_i;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - C_PH_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tc_o = (cnt_q == C_PH_W'(1));

endmodule

`default_nettype wire

// File: rtl/sram_bus_master.sv
// ------------------------------------------------------------------
// sram_bus_master : single-request SRAM + bus-transceiver strobe sequencer. Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module sram_bus_master
   import sram_bus_pkg::*;
#(
   parameter int unsigned ADDR_W     = 8,
   parameter int unsigned DATA_W     = 8,
   parameter int unsigned SETUP_CYC  = C_SETUP_CYC_DEF,
   parameter int unsigned PULSE_CYC  = C_PULSE_CYC_DEF,
   parameter int unsigned ACCESS_CYC = C_ACCESS_CYC_DEF,
   parameter bit          INVERT_RD  = 1'b0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_rdata,
   output logic [ADDR_W-1:0] ram_a,
   output logic [DATA_W-1:0] ram_d,
   output logic              ram_d_oe,
   output logic              cs_n,
   output logic              we_n,
   output logic              bt_oe_n,
   output logic              bt_dir,
   input  logic [DATA_W-1:0] bus_b_in
);

   localparam logic [C_PH_W-1:0] C_SETUP  = C_PH_W'(SETUP_CYC);
   localparam logic [C_PH_W-1:0] C_PULSE  = C_PH_W'(PULSE_CYC);
   localparam logic [C_PH_W-1:0] C_ACCESS = C_PH_W'(ACCESS_CYC);

   state_e              state_q, state_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   ram_a_q, ram_a_d;
   logic [DATA_W-1:0]   ram_d_q, ram_d_d;
   logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;
   logic                cs_n_q, cs_n_d, we_n_q, we_n_d;
   logic                bt_oe_n_q, bt_oe_n_d, bt_dir_q, bt_dir_d;
   logic                ram_d_oe_q, ram_d_oe_d, resp_valid_q, resp_valid_d;
   logic                accept, tc, cnt_load;
   logic [C_PH_W-1:0]   cnt_val;
   logic [DATA_W-1:0]   rd_data;

   generate
      if (INVERT_RD) begin : g_rd_inv
         assign rd_data = ~bus_b_in;
      end else begin : g_rd_direct
         assign rd_data = bus_b_in;
      end
   endgenerate

   assign accept = req_valid && (state_q == ST_IDLE);

   sram_phase_counter u_phase (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (cnt_load),
      .load_val_i (cnt_val),
      .tc_o       (tc)
   );

   always_comb begin
      state_d  = state_q;
      cnt_load = 1'b0;
      cnt_val  = '0;
      case (state_q)
         ST_IDLE: if (accept) begin
            state_d  = ST_SETUP;
            cnt_load = 1'b1;
            cnt_val  = C_SETUP;
         end
         ST_SETUP: if (tc) begin
            cnt_load = 1'b1;
            state_d  = we_q ? ST_WPULSE : ST_RACCESS;
            cnt_val  = we_q ? C_PULSE : C_ACCESS;
         end
         ST_WPULSE: if (tc) begin
            state_d  = ST_WHOLD;
            cnt_load = 1'b1;
            cnt_val  = C_PH_W'(1);
         end
         ST_WHOLD, ST_RACCESS: if (tc) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      // Pins are registered from the next state so they switch with the FSM.
      we_d     = accept ? req_we : we_q;
      ram_a_d  = accept ? req_addr : ram_a_q;
      ram_d_d  = (accept && req_we) ? req_wdata : ram_d_q;
      bt_dir_d = accept ? ~req_we : bt_dir_q;
      // A request already waiting at completion keeps the chip selected across the turnaround.
      cs_n_d       = (state_d == ST_IDLE) ? ~((state_q != ST_IDLE) && req_valid) : 1'b0;
      we_n_d       = (state_d != ST_WPULSE);
      bt_oe_n_d    = (state_d != ST_RACCESS);
      ram_d_oe_d   = we_d && (state_d inside {ST_SETUP, ST_WPULSE, ST_WHOLD});
      resp_valid_d = (state_q != ST_IDLE) && (state_d == ST_IDLE);
      resp_rdata_d = ((state_q == ST_RACCESS) && (state_d == ST_IDLE)) ? rd_data : resp_rdata_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         we_q         <= 1'b0;
         ram_a_q      <= '0;
         ram_d_q      <= '0;
         resp_rdata_q <= '0;
         cs_n_q       <= 1'b1;
         we_n_q       <= 1'b1;
         bt_oe_n_q    <= 1'b1;
         bt_dir_q     <= 1'b0;
         ram_d_oe_q   <= 1'b0;
         resp_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         we_q         <= we_d;
         ram_a_q      <= ram_a_d;
         ram_d_q      <= ram_d_d;
         resp_rdata_q <= resp_rdata_d;
         cs_n_q       <= cs_n_d;
         we_n_q       <= we_n_d;
         bt_oe_n_q    <= bt_oe_n_d;
         bt_dir_q     <= bt_dir_d;
         ram_d_oe_q   <= ram_d_oe_d;
         resp_valid_q <= resp_valid_d;
      end
   end

   assign req_ready  = (state_q == ST_IDLE);
   assign resp_valid = resp_valid_q;
   assign resp_rdata = resp_rdata_q;
   assign ram_a      = ram_a_q;
   assign ram_d      = ram_d_q;
   assign ram_d_oe   = ram_d_oe_q;
   assign cs_n       = cs_n_q;
   assign we_n       = we_n_q;
   assign bt_oe_n    = bt_oe_n_q;
   assign bt_dir     = bt_dir_q;

endmodule

`default_nettype wire
